// File: rtl/fixed_matmul_tile_scheduler.sv
// Tile scheduler for the int8 dequantising matmul core: walks row -> col -> depth fetch beats,
// tags returning results with their (row,col) tile and bounds in-flight tiles with credits.
module fixed_matmul_tile_scheduler #(
   parameter int unsigned IN_DEPTH        = 3,
   parameter int unsigned MAX_ROW_TILES   = 16,
   parameter int unsigned MAX_COL_TILES   = 16,
   parameter int unsigned MAX_OUTSTANDING = 2,
   localparam int unsigned ROW_W = ($clog2(MAX_ROW_TILES) > 1) ? $clog2(MAX_ROW_TILES) : 1,
   localparam int unsigned COL_W = ($clog2(MAX_COL_TILES) > 1) ? $clog2(MAX_COL_TILES) : 1,
   localparam int unsigned K_W   = ($clog2(IN_DEPTH) > 1) ? $clog2(IN_DEPTH) : 1,
   localparam int unsigned CRD_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [ROW_W:0]   cfg_row_tiles,
   input  logic [COL_W:0]   cfg_col_tiles,
   output logic             busy,
   output logic             done,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [ROW_W-1:0] req_row,
   output logic [COL_W-1:0] req_col,
   output logic [K_W-1:0]   req_k,
   output logic             req_last,
   input  logic             core_out_valid,
   output logic             core_out_ready,
   output logic             sink_valid,
   input  logic             sink_ready,
   output logic [ROW_W-1:0] sink_row,
   output logic [COL_W-1:0] sink_col
);

   localparam int unsigned TOT_W = ROW_W + COL_W + 2;
   localparam logic [ROW_W:0]   RowMax = (ROW_W + 1)'(MAX_ROW_TILES);
   localparam logic [COL_W:0]   ColMax = (COL_W + 1)'(MAX_COL_TILES);
   localparam logic [K_W-1:0]   KLast  = K_W'(IN_DEPTH - 1);
   localparam logic [CRD_W-1:0] CrdMax = CRD_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [ROW_W:0]     rows_q, rows_d;
   logic [COL_W:0]     cols_q, cols_d;
   logic [ROW_W-1:0]   r_q, r_d, out_r_q, out_r_d;
   logic [COL_W-1:0]   c_q, c_d, out_c_q, out_c_d;
   logic [K_W-1:0]     k_q, k_d;
   logic [TOT_W-1:0]   out_cnt_q, out_cnt_d;
   logic [CRD_W-1:0]   credit_q, credit_d;

   logic [ROW_W:0]     rows_clamp;
   logic [COL_W:0]     cols_clamp;
   logic [TOT_W-1:0]   total;
   logic               k_last, c_last, r_last, out_c_last;
   logic               req_fire, out_fire, credit_inc, credit_dec;

   always_comb begin
      rows_clamp = (cfg_row_tiles > RowMax) ? RowMax : cfg_row_tiles;
      cols_clamp = (cfg_col_tiles > ColMax) ? ColMax : cfg_col_tiles;
   end

   assign total      = TOT_W'(rows_q) * TOT_W'(cols_q);
   assign k_last     = (k_q == KLast);
   assign c_last     = ({1'b0, c_q} == cols_q - 1'b1);
   assign r_last     = ({1'b0, r_q} == rows_q - 1'b1);
   assign out_c_last = ({1'b0, out_c_q} == cols_q - 1'b1);

   // A tile already in progress may always finish its depth beats; only new tiles need credit.
   assign req_valid = (state_q == StIssue) && ((k_q != '0) || (credit_q < CrdMax));
   assign req_row   = r_q;
   assign req_col   = c_q;
   assign req_k     = k_q;
   assign req_last  = k_last;

   assign sink_valid     = core_out_valid;
   assign core_out_ready = sink_ready;
   assign sink_row       = out_r_q;
   assign sink_col       = out_c_q;

   assign busy = (state_q == StIssue) || (state_q == StDrain);
   assign done = (state_q == StDone);

   assign req_fire   = req_valid && req_ready;
   assign out_fire   = core_out_valid && sink_ready;
   assign credit_inc = req_fire && (k_q == '0);
   assign credit_dec = out_fire && (credit_q != '0);

   always_comb begin
      state_d   = state_q;
      rows_d    = rows_q;
      cols_d    = cols_q;
      r_d       = r_q;
      c_d       = c_q;
      k_d       = k_q;
      out_r_d   = out_r_q;
      out_c_d   = out_c_q;
      out_cnt_d = out_cnt_q;
      credit_d  = credit_q;

      case ({credit_inc, credit_dec})
         2'b10:   credit_d = credit_q + 1'b1;
         2'b01:   credit_d = credit_q - 1'b1;
         default: credit_d = credit_q;
      endcase

      if (out_fire) begin
         out_cnt_d = out_cnt_q + 1'b1;
         if (out_c_last) begin
            out_c_d = '0;
            out_r_d = out_r_q + 1'b1;
         end else begin
            out_c_d = out_c_q + 1'b1;
         end
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               rows_d    = rows_clamp;
               cols_d    = cols_clamp;
               r_d       = '0;
               c_d       = '0;
               k_d       = '0;
               out_r_d   = '0;
               out_c_d   = '0;
               out_cnt_d = '0;
               // An empty run still spends one busy cycle in drain, which sees zero tiles.
               if ((rows_clamp == '0) || (cols_clamp == '0)) state_d = StDrain;
               else                                          state_d = StIssue;
            end
         end
         StIssue: begin
            if (req_fire) begin
               if (k_last) begin
                  k_d = '0;
                  if (c_last) begin
                     c_d = '0;
                     if (r_last) begin
                        r_d     = '0;
                        state_d = StDrain;
                     end else begin
                        r_d = r_q + 1'b1;
                     end
                  end else begin
                     c_d = c_q + 1'b1;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         StDrain: begin
            if (out_cnt_d == total) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         rows_q    <= '0;
         cols_q    <= '0;
         r_q       <= '0;
         c_q       <= '0;
         k_q       <= '0;
         out_r_q   <= '0;
         out_c_q   <= '0;
         out_cnt_q <= '0;
         credit_q  <= '0;
      end else begin
         state_q   <= state_d;
         rows_q    <= rows_d;
         cols_q    <= cols_d;
         r_q       <= r_d;
         c_q       <= c_d;
         k_q       <= k_d;
         out_r_q   <= out_r_d;
         out_c_q   <= out_c_d;
         out_cnt_q <= out_cnt_d;
         credit_q  <= credit_d;
      end
   end

   no_result_without_credit: assert property (
      @(posedge clk) disable iff (rst) core_out_valid |-> (credit_q != '0)
   );

endmodule
